// File: rtl/pq_drain_sequencer.sv
`default_nettype none
// ============================================================================
// pq_drain_sequencer: pops a priority queue head, paces pops, streams via FIFO.
// Optional PQ_DRAIN_ABORT_EN adds i_abort. Rev 1.0
// ============================================================================
module pq_drain_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int BUF_DEPTH     = 2
) (
  input  logic                        i_CLK,
  input  logic                        i_RST,
  input  logic                        i_start,
  input  logic [$clog2(QUEUE_SIZE):0] i_count,
  input  logic                        i_q_empty,
  input  logic [DATA_WIDTH-1:0]       i_q_data,
  output logic                        o_q_read,
  output logic                        o_valid,
  output logic [DATA_WIDTH-1:0]       o_data,
  input  logic                        i_ready,
`ifdef PQ_DRAIN_ABORT_EN
  input  logic                        i_abort,
`endif
  output logic                        o_busy,
  output logic                        o_done,
  output logic [$clog2(QUEUE_SIZE):0] o_drained
);

  localparam int CW = $clog2(QUEUE_SIZE) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_SETTLE = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic [CW-1:0]         drained_q, drained_d;
  logic                  bounded_q, bounded_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;

  logic [PW-1:0] fill;
  logic          buf_empty, buf_full, buf_rd, abort_act, pop_go;

  assign fill      = wr_q - rd_q;
  assign buf_empty = (fill == '0);
  assign buf_full  = fill[AW];
  assign buf_rd    = !buf_empty && i_ready;

`ifdef PQ_DRAIN_ABORT_EN
  assign abort_act = i_abort && (state_q != S_IDLE) && (state_q != S_DONE);
`else
  assign abort_act = 1'b0;
`endif

  // A full buffer may still accept a pop in the cycle its head is being read.
  assign pop_go = (state_q == S_POP) && !i_q_empty && !(bounded_q && (rem_q == '0))
                  && (!buf_full || buf_rd) && !abort_act;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    drained_d = drained_q;
    bounded_d = bounded_q;
    settle_d  = settle_q;
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = buf_rd ? rd_q + PW'(1) : rd_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rem_d     = i_count;
          bounded_d = (i_count != '0);
          drained_d = '0;
          state_d   = S_POP;
        end
      end
      S_POP: begin
        if (i_q_empty || (bounded_q && (rem_q == '0))) begin
          state_d = S_FLUSH;
        end else if (pop_go) begin
          mem_d[wr_q[AW-1:0]] = i_q_data;
          wr_d      = wr_q + PW'(1);
          rem_d     = rem_q - CW'(1);
          drained_d = drained_q + CW'(1);
          settle_d  = SW'(SETTLE_CYCLES);
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q <= SW'(1)) begin
          state_d = S_POP;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      S_FLUSH: begin
        if (buf_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort drops everything buffered by collapsing the read pointer onto the write pointer.
    if (abort_act) begin
      state_d = S_DONE;
      wr_d    = wr_q;
      rd_d    = wr_q;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      drained_q <= '0;
      bounded_q <= 1'b0;
      settle_q  <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      drained_q <= drained_d;
      bounded_q <= bounded_d;
      settle_q  <= settle_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  assign o_q_read  = pop_go;
  assign o_valid   = !buf_empty;
  assign o_data    = mem_q[rd_q[AW-1:0]];
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_drained = drained_q;

endmodule
`default_nettype wire

// File: tb/tb_pq_drain_sequencer.sv
`default_nettype none
// Bench for pq_drain_sequencer: behavioural priority-queue model, vector table and scoreboard.
module tb_pq_drain_sequencer;
  localparam int DW = 16;
  localparam int QS = 4;
  localparam int ST = 1;
  localparam int BD = 2;
  localparam int CW = $clog2(QS) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_ready = 1'b0;
  logic [CW-1:0] i_count = '0;
  logic          i_q_empty;
  logic [DW-1:0] i_q_data;
  logic          o_q_read, o_valid, o_busy, o_done;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_drained;
`ifdef PQ_DRAIN_ABORT_EN
  logic          i_abort = 1'b0;
`endif

  logic [DW-1:0] qm [QS];
  int            qsize = 0;
  assign i_q_empty = (qsize == 0);
  assign i_q_data  = (qsize > 0) ? qm[0] : '0;

  always #5 clk = ~clk;

  pq_drain_sequencer #(
    .DATA_WIDTH(DW), .QUEUE_SIZE(QS), .SETTLE_CYCLES(ST), .BUF_DEPTH(BD)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_start(i_start), .i_count(i_count),
    .i_q_empty(i_q_empty), .i_q_data(i_q_data), .o_q_read(o_q_read),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
`ifdef PQ_DRAIN_ABORT_EN
    .i_abort(i_abort),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_drained(o_drained)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [QS-1:0][DW-1:0] vals;   // vals[0] is the queue head
    int n;
    int count;
    int pops;
  } vec_t;
  vec_t tbl [7];

  logic [DW-1:0] sb [$];
  int  cyc = 0, pops = 0, dones = 0, last_pop = -1;
  bit  spacing_en = 1'b1, stab_en = 1'b1, stall_prev = 1'b0, pop_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (stab_en && stall_prev) begin
      chk("stall_valid", o_valid, 1);
      chk("stall_data", o_data, stall_data);
    end
    stall_prev = o_valid && !i_ready && !rst;
    stall_data = o_data;
    if (o_q_read) begin
      pops++;
      chk("read_nonempty", i_q_empty, 0);
      if (spacing_en && last_pop >= 0) chk("pop_spacing", cyc - last_pop, ST + 1);
      last_pop = cyc;
      pop_pend = 1'b1;
    end
    if (o_valid && i_ready && !rst) begin
      chk("sb_has_item", sb.size() > 0, 1);
      if (sb.size() > 0) chk("out_data", o_data, sb.pop_front());
    end
    if (o_done) dones++;
  end

  // The queue removes its head on the edge where the pop strobe is seen.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      for (int i = 0; i < QS - 1; i++) qm[i] = qm[i+1];
      qm[QS-1] = '0;
      if (qsize > 0) qsize--;
      pop_pend = 1'b0;
    end
  end

  task automatic load_q(input logic [QS-1:0][DW-1:0] v, input int n);
    for (int i = 0; i < QS; i++) qm[i] = v[i];
    qsize = n;
    pops = 0; dones = 0; last_pop = -1;
  endtask

  task automatic start_drain(input int count);
    i_start = 1'b1;
    i_count = CW'(count);
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!o_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", o_done, 1);
    @(posedge clk); #1;
  endtask

  int k;

  initial begin
    tbl[0] = '{ {16'd2, 16'd5, 16'd7, 16'd9}, 4, 0, 4 };
    tbl[1] = '{ {16'd2, 16'd5, 16'd7, 16'd9}, 4, 2, 2 };
    tbl[2] = '{ {16'd0, 16'd0, 16'd0, 16'd0}, 0, 0, 0 };
    tbl[3] = '{ {16'd2, 16'd5, 16'd7, 16'd9}, 4, 7, 4 };
    tbl[4] = '{ {16'd0, 16'd0, 16'd0, 16'd8}, 2, 0, 2 };
    tbl[5] = '{ {16'd0, 16'd0, 16'd0, 16'd3}, 1, 4, 1 };
    tbl[6] = '{ {16'd1, 16'd4, 16'd5, 16'd6}, 4, 3, 3 };

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_read", o_q_read, 0);
    chk("rst_done", o_done, 0);
    chk("rst_drained", o_drained, 0);
    chk("rst_data", o_data, 0);
    rst = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) begin
      load_q(tbl[t].vals, tbl[t].n);
      for (int i = 0; i < tbl[t].pops; i++) sb.push_back(tbl[t].vals[i]);
      start_drain(tbl[t].count);
      wait_done(k);
      if (tbl[t].n == 0) chk("empty_done_lat", k, 3);
      chk("vec_busy_after", o_busy, 0);
      chk("vec_pops", pops, tbl[t].pops);
      chk("vec_drained", o_drained, tbl[t].pops);
      chk("vec_sb_empty", sb.size(), 0);
      chk("vec_q_left", qsize, tbl[t].n - tbl[t].pops);
      chk("vec_done_once", dones, 1);
    end

    // Downstream stall: buffer fills after two pops, head held until ready returns.
    load_q({16'd2, 16'd5, 16'd7, 16'd9}, 4);
    sb.push_back(16'd9); sb.push_back(16'd7); sb.push_back(16'd5); sb.push_back(16'd2);
    spacing_en = 1'b0;
    i_ready = 1'b0;
    start_drain(0);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_pops", pops, 2);
    chk("stall_hold_valid", o_valid, 1);
    chk("stall_hold_data", o_data, 9);
    i_ready = 1'b1;
    wait_done(k);
    chk("stall_total_pops", pops, 4);
    chk("stall_drained", o_drained, 4);
    chk("stall_sb_empty", sb.size(), 0);
    spacing_en = 1'b1;

    // Reset while settling after the first pop.
    load_q({16'd2, 16'd5, 16'd7, 16'd9}, 4);
    sb.push_back(16'd9);
    start_drain(0);
    @(posedge clk); #1;
    chk("mid_busy", o_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_read", o_q_read, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_done", dones, 0);
    chk("mid_rst_pops", pops, 1);
    chk("mid_rst_drained", o_drained, 0);
    sb.delete();

`ifdef PQ_DRAIN_ABORT_EN
    load_q({16'd2, 16'd5, 16'd7, 16'd9}, 4);
    i_ready = 1'b0;
    stab_en = 1'b0;
    start_drain(0);
    @(posedge clk); #1;
    chk("abort_pre_valid", o_valid, 1);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk("abort_valid", o_valid, 0);
    chk("abort_done", o_done, 1);
    chk("abort_drained", o_drained, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_pops", pops, 1);
    chk("abort_done_once", dones, 1);
    chk("abort_idle", o_busy, 0);
    stab_en = 1'b1;
    i_ready = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
